lcd_mode_sequencer: RTL and testbench

- Dot-timing controller for the LCD pipeline.
- Counts dots and lines, and sequences RenderMode (OAM, BOTH, HBLANK, VBLANK) per line.
- Maintains LY and the LY==LYC coincidence flag, and raises the STAT and VBLANK interrupt requests.
- Grants CPU access to VRAM and OAM according to mode.
- Sits between the LCDC/STAT/position register file and the pixel fetcher, sprite scanner and CPU bus arbiter.

---
 rtl/lcd_mode_sequencer_pkg.sv | 39 +++
 rtl/lcd_mode_sequencer_if.sv | 31 +++
 rtl/lcd_mode_sequencer_stat_irq.sv | 56 +++++
 rtl/lcd_mode_sequencer.sv | 98 +++++++++
 tb/tb_lcd_mode_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_mode_sequencer_pkg.sv
// Shared LCD timing constants, render-mode encoding and STAT source layout
// used by the mode sequencer, its STAT interrupt block and their users.
package lcd_mode_sequencer_pkg;

  localparam logic [8:0] LCD_DOTS_PER_LINE = 9'd456;
  localparam logic [8:0] LCD_OAM_DOTS      = 9'd80;
  localparam logic [8:0] LCD_XFER_DOTS     = 9'd172;
  localparam logic [7:0] LCD_LINES         = 8'd144;
  localparam logic [7:0] LCD_TOTAL_LINES   = 8'd154;

  // Encoding matches the two STAT mode bits seen by the CPU.
  typedef enum logic [1:0] {
    RENDER_HBLANK = 2'd0,
    RENDER_VBLANK = 2'd1,
    RENDER_OAM    = 2'd2,
    RENDER_BOTH   = 2'd3
  } RenderMode;

  // Bit order matches the stat_ie enable vector.
  typedef struct packed {
    logic lyc;
    logic mode2;
    logic mode1;
    logic mode0;
  } StatSources;

  function automatic RenderMode mode_for(input logic [8:0] dot_x, input logic [7:0] ly);
    if (ly >= LCD_LINES) begin
      return RENDER_VBLANK;
    end else if (dot_x < LCD_OAM_DOTS) begin
      return RENDER_OAM;
    end else if (dot_x < LCD_OAM_DOTS + LCD_XFER_DOTS) begin
      return RENDER_BOTH;
    end else begin
      return RENDER_HBLANK;
    end
  endfunction

endpackage

// File: rtl/lcd_mode_sequencer_if.sv
// Register-file side controls in, timing/status outputs back out.
// master = register file / consumers, slave = the sequencer.
interface lcd_mode_sequencer_if;

  logic                                 dot_en;
  logic                                 lcd_enable;
  logic [3:0]                           stat_ie;
  logic [7:0]                           lyc;
  logic [7:0]                           ly;
  logic [8:0]                           dot_x;
  lcd_mode_sequencer_pkg::RenderMode    mode;
  logic                                 coincidence;
  logic                                 line_start;
  logic                                 stat_irq;
  logic                                 vblank_irq;
  logic                                 cpu_vram_ok;
  logic                                 cpu_oam_ok;

  modport master (
    output dot_en, lcd_enable, stat_ie, lyc,
    input  ly, dot_x, mode, coincidence, line_start, stat_irq, vblank_irq,
           cpu_vram_ok, cpu_oam_ok
  );

  modport slave (
    input  dot_en, lcd_enable, stat_ie, lyc,
    output ly, dot_x, mode, coincidence, line_start, stat_irq, vblank_irq,
           cpu_vram_ok, cpu_oam_ok
  );

endinterface

// File: rtl/lcd_mode_sequencer_stat_irq.sv
// STAT interrupt combiner: masks the four sources and pulses on rising edges.
// Define STAT_IRQ_BLOCKING_EN to fire only on the OR-ed line's 0->1 edge.
module lcd_stat_irq
  import lcd_mode_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  RenderMode  mode,
  input  logic       coincidence,
  input  logic [3:0] stat_ie,
  input  logic       lcd_enable,
  output logic       stat_irq
);

  StatSources raw;
  logic [3:0] raw_bits;
  logic [3:0] masked;
  logic [3:0] hist_reg;
  logic       stat_irq_reg;
  logic       irq_next;

  assign raw.lyc   = coincidence;
  assign raw.mode2 = (mode == RENDER_OAM);
  assign raw.mode1 = (mode == RENDER_VBLANK);
  assign raw.mode0 = (mode == RENDER_HBLANK);
  assign raw_bits  = raw;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign masked[gi] = raw_bits[gi] & stat_ie[gi];
  end

  always_comb begin
`ifdef STAT_IRQ_BLOCKING_EN
    irq_next = (|masked) && !(|hist_reg);
`else
    irq_next = |(masked & ~hist_reg);
`endif
  end

  // History is dropped while the LCD is off so re-enabling starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_reg     <= '0;
      stat_irq_reg <= 1'b0;
    end else if (!lcd_enable) begin
      hist_reg     <= '0;
      stat_irq_reg <= 1'b0;
    end else begin
      hist_reg     <= masked;
      stat_irq_reg <= irq_next;
    end
  end

  assign stat_irq = stat_irq_reg;

endmodule

// File: rtl/lcd_mode_sequencer.sv
// LCD dot/line timing, render-mode sequencing, LY/LYC compare and CPU grants.
// STAT_IRQ_BLOCKING_EN selects the combined-line STAT interrupt behaviour.
module lcd_mode_sequencer
  import lcd_mode_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  lcd_mode_sequencer_if.slave  bus
);

  logic       started_reg;
  logic [8:0] dot_x_reg, dot_x_next;
  logic [7:0] ly_reg, ly_next;
  RenderMode  mode_reg, mode_next;
  logic       coincidence_reg;
  logic       line_start_reg;
  logic       vblank_irq_reg;
  logic       cpu_vram_ok_reg;
  logic       cpu_oam_ok_reg;
  logic       stat_irq_w;

  // The first strobe after enable lands on dot 0 of line 0 instead of advancing.
  always_comb begin
    dot_x_next = dot_x_reg;
    ly_next    = ly_reg;
    if (bus.dot_en) begin
      if (!started_reg) begin
        dot_x_next = 9'd0;
        ly_next    = 8'd0;
      end else if (dot_x_reg == LCD_DOTS_PER_LINE - 9'd1) begin
        dot_x_next = 9'd0;
        ly_next    = (ly_reg == LCD_TOTAL_LINES - 8'd1) ? 8'd0 : ly_reg + 8'd1;
      end else begin
        dot_x_next = dot_x_reg + 9'd1;
      end
    end
    mode_next = mode_for(dot_x_next, ly_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started_reg     <= 1'b0;
      dot_x_reg       <= 9'd0;
      ly_reg          <= 8'd0;
      mode_reg        <= RENDER_HBLANK;
      coincidence_reg <= 1'b0;
      line_start_reg  <= 1'b0;
      vblank_irq_reg  <= 1'b0;
      cpu_vram_ok_reg <= 1'b1;
      cpu_oam_ok_reg  <= 1'b1;
    end else if (!bus.lcd_enable) begin
      started_reg     <= 1'b0;
      dot_x_reg       <= 9'd0;
      ly_reg          <= 8'd0;
      mode_reg        <= RENDER_HBLANK;
      coincidence_reg <= 1'b0;
      line_start_reg  <= 1'b0;
      vblank_irq_reg  <= 1'b0;
      cpu_vram_ok_reg <= 1'b1;
      cpu_oam_ok_reg  <= 1'b1;
    end else begin
      // LY==LYC tracks lyc writes every clock, not just on dot strobes.
      coincidence_reg <= (ly_next == bus.lyc);
      line_start_reg  <= bus.dot_en && (dot_x_next == 9'd0) && (ly_next < LCD_LINES);
      vblank_irq_reg  <= bus.dot_en && started_reg &&
                         (ly_reg == LCD_LINES - 8'd1) && (ly_next == LCD_LINES);
      if (bus.dot_en) begin
        started_reg     <= 1'b1;
        dot_x_reg       <= dot_x_next;
        ly_reg          <= ly_next;
        mode_reg        <= mode_next;
        cpu_oam_ok_reg  <= !((mode_next == RENDER_OAM) || (mode_next == RENDER_BOTH));
        cpu_vram_ok_reg <= (mode_next != RENDER_BOTH);
      end
    end
  end

  lcd_stat_irq u_stat_irq (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode_reg),
    .coincidence (coincidence_reg),
    .stat_ie     (bus.stat_ie),
    .lcd_enable  (bus.lcd_enable),
    .stat_irq    (stat_irq_w)
  );

  assign bus.ly          = ly_reg;
  assign bus.dot_x       = dot_x_reg;
  assign bus.mode        = mode_reg;
  assign bus.coincidence = coincidence_reg;
  assign bus.line_start  = line_start_reg;
  assign bus.vblank_irq  = vblank_irq_reg;
  assign bus.cpu_vram_ok = cpu_vram_ok_reg;
  assign bus.cpu_oam_ok  = cpu_oam_ok_reg;
  assign bus.stat_irq    = stat_irq_w;

endmodule

// File: tb/tb_lcd_mode_sequencer.sv
// Bench for lcd_mode_sequencer: frame-position reference model checked every
// cycle, a strobe-count vector table, and hand sequences for corner cases.
module tb_lcd_mode_sequencer;
  import lcd_mode_sequencer_pkg::*;

  localparam int DPL   = 456;
  localparam int OAMD  = 80;
  localparam int XFER  = 172;
  localparam int VIS   = 144;
  localparam int TOT   = 154;
  localparam int FRAME = DPL * TOT;

  localparam bit [1:0] M_HB   = 2'(RENDER_HBLANK);
  localparam bit [1:0] M_VB   = 2'(RENDER_VBLANK);
  localparam bit [1:0] M_OAM  = 2'(RENDER_OAM);
  localparam bit [1:0] M_BOTH = 2'(RENDER_BOTH);

  logic clk = 1'b0;
  logic rst;
  lcd_mode_sequencer_if bus();

  lcd_mode_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int stat_cnt = 0;
  int ls_cnt   = 0;
  int vb_cnt   = 0;

  // Reference model: the whole frame is a single dot position 0..FRAME-1.
  typedef struct packed {
    bit       started;
    int       pos;
    bit [1:0] mode;
    bit       coinc;
    bit       ls;
    bit       vb;
    bit       oam_ok;
    bit       vram_ok;
    bit       stat;
    bit [3:0] hist;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_reset();
    mstate_t n;
    n = '0;
    n.mode    = M_HB;
    n.oam_ok  = 1'b1;
    n.vram_ok = 1'b1;
    return n;
  endfunction

  function automatic mstate_t model_step(mstate_t s, logic den, logic en,
                                         logic [3:0] ie, logic [7:0] lyc);
    mstate_t n;
    bit [3:0] src;
    int line, dot;
    n      = s;
    n.ls   = 1'b0;
    n.vb   = 1'b0;
    n.stat = 1'b0;
    if (!en) begin
      n = model_reset();
      return n;
    end
    src = {s.coinc, s.mode == M_OAM, s.mode == M_VB, s.mode == M_HB} & ie;
`ifdef STAT_IRQ_BLOCKING_EN
    n.stat = (src != 4'b0) && (s.hist == 4'b0);
`else
    n.stat = ((src & ~s.hist) != 4'b0);
`endif
    n.hist = src;
    if (den) begin
      if (!s.started) begin
        n.started = 1'b1;
        n.pos     = 0;
      end else begin
        n.pos = (s.pos + 1) % FRAME;
      end
      line = n.pos / DPL;
      dot  = n.pos % DPL;
      if (line >= VIS)              n.mode = M_VB;
      else if (dot < OAMD)          n.mode = M_OAM;
      else if (dot < OAMD + XFER)   n.mode = M_BOTH;
      else                          n.mode = M_HB;
      n.oam_ok  = !(n.mode == M_OAM || n.mode == M_BOTH);
      n.vram_ok = (n.mode != M_BOTH);
      n.ls      = (dot == 0) && (line < VIS);
      n.vb      = (n.pos == VIS * DPL);
    end
    n.coinc = ((n.pos / DPL) == int'(lyc));
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, bus.dot_en, bus.lcd_enable, bus.stat_ie, bus.lyc);
  end

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
      if (failures >= 50) finish_run();
    end
  endtask

  // One clock: drive dot_en, then sample 1ns after the edge and compare all outputs.
  task automatic cyc(input logic den);
    logic [31:0] act_v, exp_v;
    bus.dot_en = den;
    @(posedge clk);
    #1;
    act_v = {7'b0, bus.ly, bus.dot_x, bus.mode, bus.coincidence, bus.line_start,
             bus.vblank_irq, bus.stat_irq, bus.cpu_vram_ok, bus.cpu_oam_ok};
    exp_v = {7'b0, 8'(m.pos / DPL), 9'(m.pos % DPL), m.mode, m.coinc, m.ls,
             m.vb, m.stat, m.vram_ok, m.oam_ok};
    check("model_cycle", act_v, exp_v);
    stat_cnt += int'(bus.stat_irq);
    ls_cnt   += int'(bus.line_start);
    vb_cnt   += int'(bus.vblank_irq);
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (!(m.started && m.pos == target)) begin
      cyc(1'b1);
      guard++;
      if (guard > FRAME + 10) begin
        checks++;
        failures++;
        $display("FAIL run_to_timeout: got pos %0d expected %0d", m.pos, target);
        break;
      end
    end
  endtask

  task automatic clear_counts();
    stat_cnt = 0;
    ls_cnt   = 0;
    vb_cnt   = 0;
  endtask

  typedef struct {
    int       strobes;
    int       ly;
    int       dx;
    bit [1:0] mode;
    bit       oam_ok;
    bit       vram_ok;
    bit       coinc;
    bit       ls;
    bit       vb;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int strobes;
    int exp_l4;

    // Strobe counts from enable; strobe 1 enters dot 0 of line 0. lyc = 5.
    tbl[0]  = '{1,                 0,   0, M_OAM,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{80,                0,  79, M_OAM,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{81,                0,  80, M_BOTH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{252,               0, 251, M_BOTH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{253,               0, 252, M_HB,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{456,               0, 455, M_HB,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{457,               1,   0, M_OAM,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{5*456+1,           5,   0, M_OAM,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{5*456+2,           5,   1, M_OAM,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{6*456+1,           6,   0, M_OAM,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{144*456,         143, 455, M_HB,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{144*456+1,       144,   0, M_VB,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{144*456+2,       144,   1, M_VB,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{154*456,         153, 455, M_VB,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{154*456+1,         0,   0, M_OAM,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst            = 1'b1;
    bus.dot_en     = 1'b0;
    bus.lcd_enable = 1'b0;
    bus.stat_ie    = 4'b0000;
    bus.lyc        = 8'd0;
    repeat (3) cyc(1'b0);
    check("reset_ly",    32'(bus.ly), 32'd0);
    check("reset_dot_x", 32'(bus.dot_x), 32'd0);
    check("reset_mode",  32'(bus.mode), 32'(M_HB));
    check("reset_grants", {30'b0, bus.cpu_vram_ok, bus.cpu_oam_ok}, 32'b11);
    check("reset_pulses", {28'b0, bus.coincidence, bus.line_start, bus.vblank_irq, bus.stat_irq}, 32'd0);
    $display("reset: ly=%0d dot_x=%0d mode=%0d", bus.ly, bus.dot_x, bus.mode);

    rst            = 1'b0;
    bus.lcd_enable = 1'b1;
    bus.lyc        = 8'd5;
    bus.stat_ie    = 4'b1000;
    cyc(1'b0);
    clear_counts();

    strobes = 0;
    for (int i = 0; i < 15; i++) begin
      while (strobes < tbl[i].strobes) begin
        cyc(1'b1);
        strobes++;
      end
      check($sformatf("vec%0d_ly", i),      32'(bus.ly), 32'(tbl[i].ly));
      check($sformatf("vec%0d_dot_x", i),   32'(bus.dot_x), 32'(tbl[i].dx));
      check($sformatf("vec%0d_mode", i),    32'(bus.mode), 32'(tbl[i].mode));
      check($sformatf("vec%0d_grants", i),  {30'b0, bus.cpu_oam_ok, bus.cpu_vram_ok},
                                            {30'b0, tbl[i].oam_ok, tbl[i].vram_ok});
      check($sformatf("vec%0d_flags", i),   {29'b0, bus.coincidence, bus.line_start, bus.vblank_irq},
                                            {29'b0, tbl[i].coinc, tbl[i].ls, tbl[i].vb});
      $display("vec %0d: strobes=%0d ly=%0d dot_x=%0d mode=%0d", i, strobes, bus.ly, bus.dot_x, bus.mode);
    end
    check("frame_vblank_pulses", 32'(vb_cnt), 32'd1);
    check("frame_lyc5_stat_pulses", 32'(stat_cnt), 32'd1);
    $display("frame: vblank pulses=%0d stat pulses=%0d", vb_cnt, stat_cnt);

    // LYC and Mode2 rising together at line 3, then Mode2 alone at line 4.
    bus.lyc     = 8'd3;
    bus.stat_ie = 4'b1100;
    run_to(3*DPL - 1);
    clear_counts();
    cyc(1'b1);
    check("l3_coinc", 32'(bus.coincidence), 32'd1);
    repeat (10) cyc(1'b1);
    check("l3_stat_pulses", 32'(stat_cnt), 32'd1);
    $display("line3: stat pulses=%0d", stat_cnt);
    run_to(4*DPL - 1);
    clear_counts();
    cyc(1'b1);
    check("l4_coinc_clear", 32'(bus.coincidence), 32'd0);
    repeat (10) cyc(1'b1);
`ifdef STAT_IRQ_BLOCKING_EN
    exp_l4 = 0;
`else
    exp_l4 = 1;
`endif
    check("l4_stat_pulses", 32'(stat_cnt), 32'(exp_l4));
    $display("line4: stat pulses=%0d", stat_cnt);

    // Freeze mid-transfer.
    run_to(4*DPL + 150);
    clear_counts();
    repeat (50) cyc(1'b0);
    check("freeze_pos", {15'b0, bus.ly, bus.dot_x}, {15'b0, 8'd4, 9'd150});
    check("freeze_mode", 32'(bus.mode), 32'(M_BOTH));
    check("freeze_pulses", 32'(stat_cnt + ls_cnt + vb_cnt), 32'd0);
    $display("freeze: ly=%0d dot_x=%0d mode=%0d", bus.ly, bus.dot_x, bus.mode);

    // lyc written to the current line while dot_en is idle.
    bus.lyc = 8'd4;
    cyc(1'b0);
    check("lyc_write_coinc", 32'(bus.coincidence), 32'd1);
    cyc(1'b0);
    check("lyc_write_stat", 32'(bus.stat_irq), 32'd1);
    $display("lyc write: coincidence=%0d", bus.coincidence);

    // Disable mid-line coinciding with a strobe; disable wins.
    run_to(4*DPL + 200);
    bus.lcd_enable = 1'b0;
    cyc(1'b1);
    check("dis_pos", {15'b0, bus.ly, bus.dot_x}, 32'd0);
    check("dis_mode", 32'(bus.mode), 32'(M_HB));
    check("dis_grants", {30'b0, bus.cpu_vram_ok, bus.cpu_oam_ok}, 32'b11);
    check("dis_pulses", {29'b0, bus.line_start, bus.vblank_irq, bus.stat_irq}, 32'd0);
    repeat (3) cyc(1'b1);
    bus.lcd_enable = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    check("reen_idle_mode", 32'(bus.mode), 32'(M_HB));
    cyc(1'b1);
    check("reen_mode", 32'(bus.mode), 32'(M_OAM));
    check("reen_line_start", 32'(bus.line_start), 32'd1);
    check("reen_pos", {15'b0, bus.ly, bus.dot_x}, 32'd0);
    $display("re-enable: mode=%0d line_start=%0d", bus.mode, bus.line_start);

    // Random traffic against the model.
    bus.lyc     = 8'd2;
    bus.stat_ie = 4'b1111;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) bus.lyc = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) bus.stat_ie = 4'($urandom_range(0, 15));
      if (bus.lcd_enable && $urandom_range(0, 599) == 0) bus.lcd_enable = 1'b0;
      else if (!bus.lcd_enable && $urandom_range(0, 3) == 0) bus.lcd_enable = 1'b1;
      cyc(1'($urandom_range(0, 3) != 0));
    end
    $display("random: ly=%0d dot_x=%0d", bus.ly, bus.dot_x);

    finish_run();
  end

endmodule
